// File: rtl/dqn_weight_loader.sv
// Streams all initial weights from a synchronous ROM into the network's weight port: hidden 1, hidden 2, output layer.
// Latency: first read 1 cycle after the start edge, first weight word 3 cycles after it, done pulse 1 cycle after the last word.
// Backpressure: i_hold freezes read issue and counters; up to two in-flight words still drain, so valid shows gaps.
module dqn_weight_loader #(
  parameter int DATA_WIDTH                    = 32,
  parameter int LAYER_WIDTH                   = 2,
  parameter int WEIGHT_COUNTER_WIDTH          = 11,
  parameter int NUMBER_OF_INPUT_NODE          = 2,
  parameter int NUMBER_OF_HIDDEN_NODE_LAYER_1 = 24,
  parameter int NUMBER_OF_HIDDEN_NODE_LAYER_2 = 24,
  parameter int NUMBER_OF_OUTPUT_NODE         = 3,
  parameter int ROM_ADDR_WIDTH                = 10
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_start,
  input  logic                            i_hold,
  output logic                            o_busy,
  output logic                            o_rom_rd_en,
  output logic [ROM_ADDR_WIDTH-1:0]       o_rom_addr,
  input  logic [DATA_WIDTH-1:0]           i_rom_data,
  output logic                            o_weight_valid,
  output logic [LAYER_WIDTH-1:0]          o_weight_layer,
  output logic [WEIGHT_COUNTER_WIDTH-1:0] o_weight_addr,
  output logic [DATA_WIDTH-1:0]           o_weight,
  output logic                            o_load_weight_done
);

  // Per-layer word counts: every node carries fan_in weights plus one bias.
  localparam int S1 = NUMBER_OF_HIDDEN_NODE_LAYER_1 * (NUMBER_OF_INPUT_NODE + 1);
  localparam int S2 = NUMBER_OF_HIDDEN_NODE_LAYER_2 * (NUMBER_OF_HIDDEN_NODE_LAYER_1 + 1);
  localparam int S3 = NUMBER_OF_OUTPUT_NODE * (NUMBER_OF_HIDDEN_NODE_LAYER_2 + 1);

  localparam logic [ROM_ADDR_WIDTH-1:0] BASE1 = '0;
  localparam logic [ROM_ADDR_WIDTH-1:0] BASE2 = ROM_ADDR_WIDTH'(S1);
  localparam logic [ROM_ADDR_WIDTH-1:0] BASE3 = ROM_ADDR_WIDTH'(S1 + S2);

  localparam logic [WEIGHT_COUNTER_WIDTH-1:0] LAST1 = WEIGHT_COUNTER_WIDTH'(S1 - 1);
  localparam logic [WEIGHT_COUNTER_WIDTH-1:0] LAST2 = WEIGHT_COUNTER_WIDTH'(S2 - 1);
  localparam logic [WEIGHT_COUNTER_WIDTH-1:0] LAST3 = WEIGHT_COUNTER_WIDTH'(S3 - 1);

  localparam logic [LAYER_WIDTH-1:0] CODE1 = LAYER_WIDTH'(1);
  localparam logic [LAYER_WIDTH-1:0] CODE2 = LAYER_WIDTH'(2);
  localparam logic [LAYER_WIDTH-1:0] CODE3 = LAYER_WIDTH'(3);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_L1,
    LOAD_L2,
    LOAD_L3,
    DRAIN,
    DONE
  } state_t;

  state_t                          state;
  logic [WEIGHT_COUNTER_WIDTH-1:0] local_cnt;

  // Layer code and local address travelling alongside the outstanding ROM read.
  logic [LAYER_WIDTH-1:0]          rd_layer;
  logic [WEIGHT_COUNTER_WIDTH-1:0] rd_local;

  // Second pipeline stage: the ROM word for this tag arrives on i_rom_data.
  logic                            s1_vld;
  logic [LAYER_WIDTH-1:0]          s1_layer;
  logic [WEIGHT_COUNTER_WIDTH-1:0] s1_addr;

  logic [ROM_ADDR_WIDTH-1:0]       cur_base;
  logic [WEIGHT_COUNTER_WIDTH-1:0] cur_last;
  logic [LAYER_WIDTH-1:0]          cur_code;
  state_t                          after_last;
  logic                            loading;
  logic                            issue;

  // Select the active layer's base, last index and code; IDLE behaves as layer 1 so the start edge issues word 0.
  always_comb begin
    cur_base   = BASE1;
    cur_last   = LAST1;
    cur_code   = CODE1;
    after_last = LOAD_L2;
    case (state)
      LOAD_L2: begin
        cur_base   = BASE2;
        cur_last   = LAST2;
        cur_code   = CODE2;
        after_last = LOAD_L3;
      end
      LOAD_L3: begin
        cur_base   = BASE3;
        cur_last   = LAST3;
        cur_code   = CODE3;
        after_last = DRAIN;
      end
      default: ;
    endcase
  end

  assign loading = (state == LOAD_L1) || (state == LOAD_L2) || (state == LOAD_L3);
  assign issue   = ((state == IDLE) && i_start) || (loading && !i_hold);

  // Control FSM: issues back-to-back reads across layer boundaries, then drains and pulses done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= IDLE;
      local_cnt          <= '0;
      o_busy             <= 1'b0;
      o_rom_rd_en        <= 1'b0;
      o_rom_addr         <= '0;
      rd_layer           <= '0;
      rd_local           <= '0;
      o_load_weight_done <= 1'b0;
    end else begin
      o_rom_rd_en        <= 1'b0;
      o_load_weight_done <= 1'b0;
      if (issue) begin
        o_rom_rd_en <= 1'b1;
        o_rom_addr  <= cur_base + ROM_ADDR_WIDTH'(local_cnt);
        rd_layer    <= cur_code;
        rd_local    <= local_cnt;
        if (local_cnt == cur_last) begin
          local_cnt <= '0;
          state     <= after_last;
        end else begin
          local_cnt <= local_cnt + 1'b1;
          if (state == IDLE) begin
            state <= LOAD_L1;
          end
        end
      end
      case (state)
        IDLE: begin
          if (i_start) begin
            o_busy <= 1'b1;
          end
        end
        DRAIN: begin
          // Done only once nothing is left in either pipeline stage.
          if (!o_rom_rd_en && !s1_vld) begin
            state              <= DONE;
            o_load_weight_done <= 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Two-stage data path: tag follows the read, then meets the ROM word and is presented together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld         <= 1'b0;
      s1_layer       <= '0;
      s1_addr        <= '0;
      o_weight_valid <= 1'b0;
      o_weight_layer <= '0;
      o_weight_addr  <= '0;
      o_weight       <= '0;
    end else begin
      s1_vld         <= o_rom_rd_en;
      o_weight_valid <= s1_vld;
      if (o_rom_rd_en) begin
        s1_layer <= rd_layer;
        s1_addr  <= rd_local;
      end
      if (s1_vld) begin
        o_weight       <= i_rom_data;
        o_weight_layer <= s1_layer;
        o_weight_addr  <= s1_addr;
      end
    end
  end

endmodule

// File: tb/tb_dqn_weight_loader.sv
// Self-checking bench for dqn_weight_loader: ROM model, expected stream from layer sizes, randomized data and hold.
module tb_dqn_weight_loader;

  localparam int DW    = 32;
  localparam int LW    = 2;
  localparam int WCW   = 11;
  localparam int RAW   = 10;
  localparam int S1    = 24 * 3;
  localparam int S2    = 24 * 25;
  localparam int S3    = 3 * 25;
  localparam int TOTAL = S1 + S2 + S3;

  logic           clk;
  logic           rst;
  logic           i_start;
  logic           i_hold;
  logic           o_busy;
  logic           o_rom_rd_en;
  logic [RAW-1:0] o_rom_addr;
  logic [DW-1:0]  i_rom_data;
  logic           o_weight_valid;
  logic [LW-1:0]  o_weight_layer;
  logic [WCW-1:0] o_weight_addr;
  logic [DW-1:0]  o_weight;
  logic           o_load_weight_done;

  dqn_weight_loader dut (
    .clk                (clk),
    .rst                (rst),
    .i_start            (i_start),
    .i_hold             (i_hold),
    .o_busy             (o_busy),
    .o_rom_rd_en        (o_rom_rd_en),
    .o_rom_addr         (o_rom_addr),
    .i_rom_data         (i_rom_data),
    .o_weight_valid     (o_weight_valid),
    .o_weight_layer     (o_weight_layer),
    .o_weight_addr      (o_weight_addr),
    .o_weight           (o_weight),
    .o_load_weight_done (o_load_weight_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM model
  logic [DW-1:0] rom [0:1023];
  always @(posedge clk) begin
    if (o_rom_rd_en) i_rom_data <= rom[o_rom_addr];
  end

  int tests;
  int fails;
  int rel;
  int idx;
  int first_rd;
  int first_vld;
  int last_vld;
  int done_cnt;
  int done_rel;
  int busy_fall;
  bit busy_q;
  bit strict;
  int hold_words;
  int hold_rds;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {5'd0, o_busy, o_rom_rd_en, o_rom_addr, o_weight_valid, o_weight_layer,
            o_weight_addr, o_weight, o_load_weight_done};
  endfunction

  // Reference stream: global word i belongs to the layer whose range covers it.
  function automatic logic [63:0] exp_word(input int i);
    int layer;
    int base;
    int loc;
    if (i < S1) begin
      layer = 1; base = 0;
    end else if (i < S1 + S2) begin
      layer = 2; base = S1;
    end else begin
      layer = 3; base = S1 + S2;
    end
    loc = i - base;
    return {19'd0, layer[1:0], loc[10:0], rom[i]};
  endfunction

  // Advance one cycle and observe outputs at the falling edge.
  task automatic tick();
    @(negedge clk);
    rel++;
    if (o_rom_rd_en && first_rd < 0) begin
      first_rd = rel;
      chk("first_rd_addr", o_rom_addr, 0);
    end
    if (o_weight_valid) begin
      if (idx < TOTAL) begin
        chk("word", {19'd0, o_weight_layer, o_weight_addr, o_weight}, exp_word(idx));
        if (strict && (idx == S1 || idx == S1 + S2))
          chk("layer_boundary_gap", rel - last_vld, 1);
      end else begin
        chk("extra_word", idx, TOTAL - 1);
      end
      if (idx == 0) first_vld = rel;
      last_vld = rel;
      idx++;
    end
    if (o_load_weight_done) begin
      done_cnt++;
      done_rel = rel;
      chk("done_after_last", rel, last_vld + 1);
    end
    if (busy_q && !o_busy) busy_fall = rel;
    busy_q = o_busy;
  endtask

  task automatic start_load();
    rel = 0; idx = 0; first_rd = -1; first_vld = -1; last_vld = -1;
    done_cnt = 0; done_rel = -1; busy_fall = -1; busy_q = o_busy;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    chk("busy_rise", o_busy, 1);
  endtask

  task automatic wait_done(input bit start_in_done);
    for (int t = 0; t < 4000 && done_cnt == 0; t++) tick();
    if (start_in_done && done_cnt != 0) begin
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
    end
    repeat (4) tick();
  endtask

  task automatic end_checks();
    chk("word_count", idx, TOTAL);
    chk("done_count", done_cnt, 1);
    chk("busy_fall", busy_fall, done_rel + 1);
    if (strict) begin
      chk("first_rd_cycle", first_rd, 1);
      chk("first_vld_cycle", first_vld, 3);
      chk("last_vld_cycle", last_vld, TOTAL + 2);
      chk("done_cycle", done_rel, TOTAL + 3);
    end
  endtask

  initial begin
    tests = 0; fails = 0; rel = 0; idx = 0; done_cnt = 0;
    first_rd = -1; first_vld = -1; last_vld = -1; done_rel = -1; busy_fall = -1;
    busy_q = 1'b0; strict = 1'b1;
    rst = 1'b1; i_start = 1'b0; i_hold = 1'b0;
    for (int i = 0; i < 1024; i++) rom[i] = i;
    #1;
    chk("reset_state", all_outs(), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    tick(); tick();

    // Basic load with ROM word i = i
    strict = 1'b1;
    start_load();
    wait_done(0);
    end_checks();

    for (int i = 0; i < 1024; i++) rom[i] = $urandom;

    // Start while busy at word 100, and start during DONE: both ignored
    strict = 1'b1;
    start_load();
    for (int t = 0; t < 400 && idx < 100; t++) tick();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    wait_done(1);
    chk("start_in_done_ignored", {o_busy, o_rom_rd_en}, 0);
    end_checks();

    // Five-cycle hold at layer-2 local 10
    strict = 1'b0;
    start_load();
    for (int t = 0; t < 500 && !(o_rom_rd_en && o_rom_addr == RAW'(S1 + 10)); t++) tick();
    chk("hold_trigger_seen", o_rom_rd_en && o_rom_addr == RAW'(S1 + 10), 1);
    hold_words = 0; hold_rds = 0;
    i_hold = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (o_weight_valid) hold_words++;
      if (o_rom_rd_en) hold_rds++;
    end
    i_hold = 1'b0;
    tick();
    if (o_weight_valid) hold_words++;
    chk("hold_inflight_le2", hold_words <= 2, 1);
    chk("hold_no_reads", hold_rds, 0);
    for (int t = 0; t < 20 && !o_weight_valid; t++) tick();
    chk("hold_resume", o_weight_valid && o_weight_layer == 2'd2 && o_weight_addr <= 11'd12, 1);
    wait_done(0);
    end_checks();

    // Random hold throughout the load
    strict = 1'b0;
    start_load();
    for (int t = 0; t < 8000 && done_cnt == 0; t++) begin
      i_hold = ($urandom_range(0, 3) == 0);
      tick();
    end
    i_hold = 1'b0;
    wait_done(0);
    end_checks();
    i_hold = 1'b1;
    repeat (5) tick();
    chk("idle_hold_no_effect", {o_busy, o_rom_rd_en, o_weight_valid}, 0);
    i_hold = 1'b0;

    // Reset mid-load at word 300
    strict = 1'b1;
    start_load();
    for (int t = 0; t < 600 && idx < 300; t++) tick();
    rst = 1'b1;
    #1;
    chk("rst_async_outputs", all_outs(), 0);
    repeat (3) tick();
    chk("rst_held_outputs", all_outs(), 0);
    chk("rst_no_done", done_cnt, 0);
    rst = 1'b0;
    tick(); tick();

    // Restart after reset begins at layer 01 addr 0
    strict = 1'b1;
    start_load();
    wait_done(0);
    end_checks();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
